// File: rtl/prog_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// prog_sequencer_pkg
// Shared configuration for the program sequencer and its program store:
//   - processor command word width and opcode field position
//   - MV / MVI / ADD / SUB opcode values
//   - default program depth
//   - sequencer state encoding
//   - small opcode helper
// ----------------------------------------------------------------------------
package prog_sequencer_pkg;

  // Processor command word: {opcode[5:4], rx[3:2], ry[1:0]}
  localparam int CMD_LENGTH = 6;
  localparam int OP_MSB     = 5;
  localparam int OP_LSB     = 4;

  localparam logic [1:0] CMD_MV  = 2'b00;
  localparam logic [1:0] CMD_MVI = 2'b01;
  localparam logic [1:0] CMD_ADD = 2'b10;
  localparam logic [1:0] CMD_SUB = 2'b11;

  localparam int PROG_DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_OPERAND = 3'd2,
    ST_WAIT    = 3'd3,
    ST_FINISH  = 3'd4
  } seq_state_e;

  // MVI is the only command followed by an immediate word.
  function automatic logic is_mvi(input logic [1:0] op);
    return (op == CMD_MVI);
  endfunction

endpackage

// File: rtl/prog_rom.sv
// ----------------------------------------------------------------------------
// prog_rom
// Program word store: synchronous write, asynchronous read, no reset
// (contents survive resetn).
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   write strobe
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  combinational read data
// ----------------------------------------------------------------------------
module prog_rom
  import prog_sequencer_pkg::*;
#(
  parameter int DEPTH = PROG_DEPTH_DEF,
  parameter int AW    = 4,
  parameter int W     = CMD_LENGTH
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Program word write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_sequencer.sv
// ----------------------------------------------------------------------------
// prog_sequencer
// Feeds a stored program, one command word at a time, to a simple
// multi-cycle processor (DIN/run/done handshake). MVI is followed by its
// immediate word; every other command waits for done. A per-instruction
// timeout and a truncated trailing MVI both raise the sticky err flag.
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   start      in   one-cycle pulse, begin at address 0 (ignored when busy)
//   abort      in   synchronous stop request, back to IDLE
//   prog_we    in   program write strobe (honoured only in IDLE)
//   prog_addr  in   program write address
//   prog_data  in   program write data
//   prog_len   in   number of valid program words, 0..PROG_DEPTH
//   done       in   processor instruction-complete flag
//   run        out  processor run
//   DIN        out  processor DIN bus
//   pc         out  address currently presented
//   busy       out  high outside IDLE
//   fin        out  one-cycle pulse at program end
//   err        out  sticky error, cleared by the next accepted start
// All outputs are registered; they are decoded from the next state.
// ----------------------------------------------------------------------------
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = PROG_DEPTH_DEF,
  parameter int AW         = 4,
  parameter int TMO        = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [CMD_LENGTH-1:0] prog_data,
  input  logic [AW:0]           prog_len,
  input  logic                  done,
  output logic                  run,
  output logic [CMD_LENGTH-1:0] DIN,
  output logic [AW-1:0]         pc,
  output logic                  busy,
  output logic                  fin,
  output logic                  err
);

  localparam int TW = $clog2(TMO + 1);

  localparam logic [AW:0]           PC_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]           PC_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [TW-1:0]         TMO_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]         TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]         TMO_LIM  = TW'(TMO);
  localparam logic [CMD_LENGTH-1:0] DIN_ZERO = {CMD_LENGTH{1'b0}};

  seq_state_e            r_state, w_state_nxt;
  // One extra bit so that pc can reach PROG_DEPTH without wrapping.
  logic [AW:0]           r_pc, w_pc_nxt, w_pc_inc;
  logic [TW-1:0]         r_tmo, w_tmo_nxt, w_tmo_inc;
  logic                  r_err, w_err_nxt;

  logic                  r_run, r_busy, r_fin;
  logic [CMD_LENGTH-1:0] r_din;
  logic                  w_run_nxt, w_busy_nxt, w_fin_nxt;
  logic [CMD_LENGTH-1:0] w_din_nxt;

  logic                  w_rom_we;
  logic [CMD_LENGTH-1:0] w_rom_rdata;
  logic                  w_len_zero;

  assign w_pc_inc   = r_pc + PC_ONE;
  assign w_tmo_inc  = r_tmo + TMO_ONE;
  assign w_len_zero = (prog_len == PC_ZERO);
  assign w_rom_we   = prog_we && (r_state == ST_IDLE);

  // The read port looks at the next pc so DIN can be registered with the state.
  prog_rom #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW),
    .W     (CMD_LENGTH)
  ) u_rom (
    .clk     (clk),
    .i_we    (w_rom_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_pc_nxt[AW-1:0]),
    .o_rdata (w_rom_rdata)
  );

  // Next-state, pc, timeout and error logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_pc_nxt  = PC_ZERO;
          w_tmo_nxt = TMO_ZERO;
          w_err_nxt = 1'b0;
          if (w_len_zero) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_tmo_nxt = TMO_ZERO;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (is_mvi(r_din[OP_MSB:OP_LSB])) begin
          w_state_nxt = ST_OPERAND;
          w_pc_nxt    = w_pc_inc;
          // Immediate word would lie past the program: flag it now.
          if (w_pc_inc >= prog_len) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_OPERAND, ST_WAIT: begin
        // abort has priority over done: pc stays where it was.
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_tmo_nxt   = TMO_ZERO;
        end else if (done) begin
          w_pc_nxt = w_pc_inc;
          if (w_pc_inc >= prog_len) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else if (w_tmo_inc >= TMO_LIM) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_FINISH;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    w_run_nxt  = 1'b0;
    w_busy_nxt = 1'b1;
    w_fin_nxt  = 1'b0;
    w_din_nxt  = DIN_ZERO;
    case (w_state_nxt)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      ST_ISSUE: begin
        w_run_nxt = 1'b1;
        w_din_nxt = w_rom_rdata;
      end
      ST_OPERAND: begin
        w_run_nxt = 1'b1;
        // Truncated MVI: present zero instead of a word beyond prog_len.
        if (w_pc_nxt < prog_len) begin
          w_din_nxt = w_rom_rdata;
        end else begin
          w_din_nxt = DIN_ZERO;
        end
      end
      ST_WAIT: begin
        w_run_nxt = 1'b1;
      end
      ST_FINISH: begin
        w_fin_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // State, pc, timeout counter and sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_pc    <= PC_ZERO;
      r_tmo   <= TMO_ZERO;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Registered processor-facing and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run  <= 1'b0;
      r_din  <= DIN_ZERO;
      r_busy <= 1'b0;
      r_fin  <= 1'b0;
    end else begin
      r_run  <= w_run_nxt;
      r_din  <= w_din_nxt;
      r_busy <= w_busy_nxt;
      r_fin  <= w_fin_nxt;
    end
  end

  assign run  = r_run;
  assign DIN  = r_din;
  assign pc   = r_pc[AW-1:0];
  assign busy = r_busy;
  assign fin  = r_fin;
  assign err  = r_err;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  localparam int W     = CMD_LENGTH;
  localparam int DEPTH = 16;
  localparam int AWB   = 4;
  localparam int TMOB  = 6;

  logic           clk = 1'b0;
  logic           resetn, start, abort, prog_we;
  logic [AWB-1:0] prog_addr;
  logic [W-1:0]   prog_data;
  logic [AWB:0]   prog_len;
  logic           done;
  logic           run, busy, fin, err;
  logic [W-1:0]   DIN;
  logic [AWB-1:0] pc;

  always #5 clk = ~clk;

  prog_sequencer #(.PROG_DEPTH(DEPTH), .AW(AWB), .TMO(TMOB)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .done(done), .run(run), .DIN(DIN), .pc(pc),
    .busy(busy), .fin(fin), .err(err)
  );

  // ---------------- processor model (drives done) ----------------
  logic [1:0]   p_tstep;
  logic [W-1:0] p_ir;
  logic [W-1:0] p_rf [4];
  logic         p_clr, done_kill, model_done;
  logic [1:0]   p_op;
  logic [W-1:0] got_q [$];

  assign p_op = p_ir[5:4];
  assign model_done = run && ((p_tstep == 2'd1 && (p_op == CMD_MV || p_op == CMD_MVI)) ||
                              (p_tstep == 2'd3 && (p_op == CMD_ADD || p_op == CMD_SUB)));
  assign done = model_done && !done_kill;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_tstep <= 2'd0;
      p_ir    <= '0;
    end else if (p_clr) begin
      p_tstep <= 2'd0;
      for (int i = 0; i < 4; i++) p_rf[i] <= '0;
      got_q.delete();
    end else if (!run) begin
      p_tstep <= 2'd0;
    end else if (p_tstep == 2'd0) begin
      p_ir <= DIN;
      got_q.push_back(DIN);
      p_tstep <= 2'd1;
    end else begin
      if (p_tstep == 2'd1) begin
        if (p_op == CMD_MV)  p_rf[p_ir[3:2]] <= p_rf[p_ir[1:0]];
        if (p_op == CMD_MVI) begin
          p_rf[p_ir[3:2]] <= DIN;
          got_q.push_back(DIN);
        end
      end
      if (p_tstep == 2'd3) begin
        if (p_op == CMD_ADD) p_rf[p_ir[3:2]] <= p_rf[p_ir[3:2]] + p_rf[p_ir[1:0]];
        if (p_op == CMD_SUB) p_rf[p_ir[3:2]] <= p_rf[p_ir[3:2]] - p_rf[p_ir[1:0]];
      end
      if (done) p_tstep <= 2'd0;
      else      p_tstep <= p_tstep + 2'd1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] mirror [DEPTH];

  task automatic load_word(input int a, input logic [W-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a[AWB-1:0];
    prog_data = d;
    tick();
    prog_we = 1'b0;
    mirror[a] = d;
  endtask

  // Start a program and follow it to fin. inj>=0 pulses start and a
  // program write at that cycle of the run (both must be ignored).
  task automatic run_prog(input int len, input int inj, output int runc,
                          output int finc, output int fpc, output logic ferr);
    logic seen;
    p_clr = 1'b1; tick(); p_clr = 1'b0;
    prog_len = len[AWB:0];
    start = 1'b1; tick(); start = 1'b0;
    runc = 0; finc = 0; fpc = 0; ferr = 1'b0; seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (run) runc++;
      if (fin) begin
        finc++; seen = 1'b1; fpc = int'(pc); ferr = err;
      end else begin
        if (k == inj) begin
          start = 1'b1; prog_we = 1'b1; prog_addr = 4'd4; prog_data = 6'h3F;
        end
        tick();
        start = 1'b0; prog_we = 1'b0;
      end
    end
    check("fin_seen", seen, 1);
    tick();
    if (fin) finc++;
    check("idle_after_fin", busy, 0);
  endtask

  // ---------------- behavioural reference ----------------
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_rf [4];

  task automatic ref_model(input int len, output int cyc, output int fpc, output logic ferr);
    int i;
    logic [W-1:0] wd, imm;
    exp_q.delete();
    for (int r = 0; r < 4; r++) exp_rf[r] = '0;
    i = 0; cyc = 0; ferr = 1'b0;
    while (i < len) begin
      wd = mirror[i];
      exp_q.push_back(wd);
      case (wd[5:4])
        CMD_MVI: begin
          if (i + 1 < len) imm = mirror[i+1];
          else begin imm = '0; ferr = 1'b1; end
          exp_q.push_back(imm);
          exp_rf[wd[3:2]] = imm; cyc += 2; i += 2;
        end
        CMD_MV:  begin exp_rf[wd[3:2]] = exp_rf[wd[1:0]]; cyc += 2; i += 1; end
        CMD_ADD: begin exp_rf[wd[3:2]] = exp_rf[wd[3:2]] + exp_rf[wd[1:0]]; cyc += 4; i += 1; end
        default: begin exp_rf[wd[3:2]] = exp_rf[wd[3:2]] - exp_rf[wd[1:0]]; cyc += 4; i += 1; end
      endcase
    end
    fpc = i % DEPTH;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0][W-1:0] words;
    int                 len;
    int                 e_run;
    int                 e_pc;
    logic               e_err;
    int                 e_ridx;
    logic [W-1:0]       e_rval;
  } vec_t;

  vec_t vt [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int runc, finc, fpc, cyc, epc, len;
    logic ferr, eerr, found;

    // MVI R0,5 ; MVI R1,3 ; ADD R0,R1
    vt[0].words = '0;
    vt[0].words[0] = 6'h10; vt[0].words[1] = 6'h05; vt[0].words[2] = 6'h14;
    vt[0].words[3] = 6'h03; vt[0].words[4] = 6'h21;
    vt[0].len = 5; vt[0].e_run = 8; vt[0].e_pc = 5; vt[0].e_err = 1'b0; vt[0].e_ridx = 0; vt[0].e_rval = 6'd8;
    // MV R1,R0
    vt[1].words = '0; vt[1].words[0] = 6'h04;
    vt[1].len = 1; vt[1].e_run = 2; vt[1].e_pc = 1; vt[1].e_err = 1'b0; vt[1].e_ridx = 1; vt[1].e_rval = 6'd0;
    // MVI R2 with no immediate
    vt[2].words = '0; vt[2].words[0] = 6'h18;
    vt[2].len = 1; vt[2].e_run = 2; vt[2].e_pc = 2; vt[2].e_err = 1'b1; vt[2].e_ridx = 2; vt[2].e_rval = 6'd0;
    // empty program
    vt[3].words = '0;
    vt[3].len = 0; vt[3].e_run = 0; vt[3].e_pc = 0; vt[3].e_err = 1'b0; vt[3].e_ridx = 0; vt[3].e_rval = 6'd0;
    // MVI R3,9 ; MVI R1,2 ; SUB R3,R1
    vt[4].words = '0;
    vt[4].words[0] = 6'h1C; vt[4].words[1] = 6'h09; vt[4].words[2] = 6'h14;
    vt[4].words[3] = 6'h02; vt[4].words[4] = 6'h3D;
    vt[4].len = 5; vt[4].e_run = 8; vt[4].e_pc = 5; vt[4].e_err = 1'b0; vt[4].e_ridx = 3; vt[4].e_rval = 6'd7;
    // full depth: MVI R1,1 then 14 x ADD R0,R1 (pc reaches 16, shown as 0)
    for (int j = 0; j < 16; j++) vt[5].words[j] = 6'h21;
    vt[5].words[0] = 6'h14; vt[5].words[1] = 6'h01;
    vt[5].len = 16; vt[5].e_run = 58; vt[5].e_pc = 0; vt[5].e_err = 1'b0; vt[5].e_ridx = 0; vt[5].e_rval = 6'd14;

    resetn = 1'b0; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; prog_len = '0; done_kill = 1'b0; p_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_run", run, 0);   check("rst_din", DIN, 0);  check("rst_pc", pc, 0);
    check("rst_busy", busy, 0); check("rst_fin", fin, 0);  check("rst_err", err, 0);
    @(negedge clk); resetn = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    // table-driven programs
    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < 16; a++) load_word(a, vt[i].words[a]);
      run_prog(vt[i].len, -1, runc, finc, fpc, ferr);
      check($sformatf("vec%0d_run", i), runc, vt[i].e_run);
      check($sformatf("vec%0d_fin", i), finc, 1);
      check($sformatf("vec%0d_pc", i), fpc, vt[i].e_pc);
      check($sformatf("vec%0d_err", i), ferr, vt[i].e_err);
      check($sformatf("vec%0d_reg", i), p_rf[vt[i].e_ridx], vt[i].e_rval);
    end

    // start and program write while busy are ignored
    for (int a = 0; a < 16; a++) load_word(a, vt[0].words[a]);
    run_prog(5, 3, runc, finc, fpc, ferr);
    check("busy_start_run", runc, 8);
    check("busy_start_pc", fpc, 5);
    run_prog(5, -1, runc, finc, fpc, ferr);
    check("busy_we_ignored_r0", p_rf[0], 8);
    check("busy_we_ignored_run", runc, 8);

    // timeout: ADD with done held low
    load_word(0, 6'h21);
    done_kill = 1'b1;
    run_prog(1, -1, runc, finc, fpc, ferr);
    done_kill = 1'b0;
    check("tmo_run", runc, 1 + TMOB);
    check("tmo_err", ferr, 1);
    check("tmo_fin", finc, 1);
    check("tmo_pc", fpc, 0);
    tick(); tick();
    check("err_sticky", err, 1);
    load_word(0, 6'h04);
    run_prog(1, -1, runc, finc, fpc, ferr);
    check("err_cleared", ferr, 0);
    check("err_clr_run", runc, 2);

    // abort together with done during the second MVI operand
    for (int a = 0; a < 5; a++) load_word(a, vt[0].words[a]);
    p_clr = 1'b1; tick(); p_clr = 1'b0;
    prog_len = 5'd5; start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (pc == 4'd3 && done && run) found = 1'b1;
      else tick();
    end
    check("abort_wait", found, 1);
    if (found) begin
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_busy", busy, 0); check("abort_run", run, 0);
      check("abort_din", DIN, 0);   check("abort_pc", pc, 3);
      check("abort_fin", fin, 0);   check("abort_err", err, 0);
      finc = 0;
      repeat (4) begin tick(); if (fin) finc++; end
      check("abort_no_fin", finc, 0);
    end

    // asynchronous reset in the middle of ADD
    p_clr = 1'b1; tick(); p_clr = 1'b0;
    prog_len = 5'd5; start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (pc == 4'd4 && run) found = 1'b1;
      else tick();
    end
    check("add_wait", found, 1);
    tick();
    #2 resetn = 1'b0;
    #1;
    check("arst_run", run, 0); check("arst_busy", busy, 0);
    check("arst_din", DIN, 0); check("arst_pc", pc, 0);
    check("arst_fin", fin, 0); check("arst_err", err, 0);
    @(negedge clk); resetn = 1'b1;
    tick();
    run_prog(0, -1, runc, finc, fpc, ferr);
    check("len0_run", runc, 0);
    check("len0_fin", finc, 1);
    run_prog(5, -1, runc, finc, fpc, ferr);
    check("mem_kept_r0", p_rf[0], 8);
    check("mem_kept_run", runc, 8);

    // randomized programs against the reference model
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 16);
      for (int a = 0; a < 16; a++) load_word(a, W'($urandom));
      ref_model(len, cyc, epc, eerr);
      run_prog(len, -1, runc, finc, fpc, ferr);
      check($sformatf("rnd%0d_run", t), runc, cyc);
      check($sformatf("rnd%0d_fin", t), finc, 1);
      check($sformatf("rnd%0d_pc", t), fpc, epc);
      check($sformatf("rnd%0d_err", t), ferr, eerr);
      check($sformatf("rnd%0d_words", t), got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size(); j++) begin
        if (j < got_q.size()) check($sformatf("rnd%0d_word%0d", t, j), got_q[j], exp_q[j]);
      end
      check($sformatf("rnd%0d_regs", t), {8'd0, p_rf[3], p_rf[2], p_rf[1], p_rf[0]},
            {8'd0, exp_rf[3], exp_rf[2], exp_rf[1], exp_rf[0]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter: PROG_DEPTH, default 16, number of program words held.
REQ-002 Parameter: AW, default 4, program address width (log2 PROG_DEPTH).
REQ-003 Parameter: TMO, default 6, maximum cycles from issue to done before timeout.
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: resetn  in  1  reset, asynchronous, active-low.
REQ-006 Port: start  in  1  one-cycle pulse; begins execution at address 0.
REQ-007 Port: abort  in  1  synchronous stop request.
REQ-008 Port: prog_we  in  1  program-word write strobe.
REQ-009 Port: prog_addr  in  AW  write address.
REQ-010 Port: prog_data  in  CMD_LENGTH  write data.
REQ-011 Port: prog_len  in  AW+1  number of valid words, 0..PROG_DEPTH.
REQ-012 Port: done  in  1  processor instruction-complete flag.
REQ-013 Port: run  out  1  to processor run input.
REQ-014 Port: DIN  out  CMD_LENGTH  to processor DIN bus.
REQ-015 Port: pc  out  AW  address currently presented.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: fin  out  1  one-cycle pulse at program end.
REQ-018 Port: err  out  1  sticky error flag; cleared by the next accepted start.

Function
REQ-019 States SHALL be IDLE, ISSUE, OPERAND, WAIT and FINISH; run=1 only in ISSUE, OPERAND and WAIT.
REQ-020 IDLE: prog_we writes prog_data to prog_addr; writes in any other state are ignored.
REQ-021 IDLE: start with prog_len!=0 -> ISSUE, pc=0, err=0; start with prog_len==0 -> FINISH, no run.
REQ-022 ISSUE: DIN=mem[pc], which the processor latches at Tstep 0; if DIN[5:4]==`CMD_MVI -> OPERAND with pc+1, else -> WAIT.
REQ-023 OPERAND: DIN=mem[pc] (immediate word, consumed at Tstep 1); if pc reached prog_len, DIN=0 and err=1 (truncated MVI).
REQ-024 WAIT: DIN=0; done must be sampled high in OPERAND or WAIT.
REQ-025 done sampled high -> pc+1; if new pc >= prog_len -> FINISH, else -> ISSUE in the next cycle.
REQ-026 Throughput: MV and MVI take 2 cycles (ISSUE + 1); ADD and SUB take 4 cycles, with no bubble between instructions.
REQ-027 Timeout counter clears on ISSUE and increments in OPERAND and WAIT; reaching TMO without done -> err=1, FINISH.
REQ-028 abort in any non-IDLE state -> IDLE next cycle with run=0 and DIN=0; fin does not pulse and err is unchanged.
REQ-029 Simultaneous abort and done: abort wins and pc does not advance.
REQ-030 start while busy is ignored.
REQ-031 FINISH: fin=1 for one cycle, run=0, then IDLE; pc holds its final value.
REQ-032 pc arithmetic is AW+1 bits internally so that prog_len==PROG_DEPTH completes without wrap.

Reset
REQ-033 resetn low SHALL asynchronously force IDLE, run=0, DIN=0, pc=0, busy=0, fin=0, err=0 and the timeout counter to 0.
REQ-034 Program memory contents are not reset.
REQ-035 Reset mid-instruction releases run immediately, and the processor clears via its own resetn.

Structure
REQ-036 CMD_LENGTH, the CMD_MV/CMD_MVI/CMD_ADD/CMD_SUB opcodes and the opcode field position [5:4] SHALL come from config.vh.
REQ-037 A PROG_DEPTH default and the state encoding constants SHALL be added to config.vh.
REQ-038 One sub-module, prog_rom: a synchronous-write, asynchronous-read register array of PROG_DEPTH x CMD_LENGTH.

Verification (bench drives done from a processor model or the real proc datapath)
REQ-039 Load [MVI R0, imm 5, MVI R1, imm 3, ADD R0 R1], prog_len=5, start -> run high 8 cycles, fin pulse, R0=8, err=0.
REQ-040 Load [MV R1 R0], prog_len=1, start -> run high exactly 2 cycles, pc ends at 1, fin once.
REQ-041 Load [MVI R2] with prog_len=1 -> operand DIN=0, err=1, fin pulse.
REQ-042 Hold done=0 after ISSUE -> err=1 after TMO=6 cycles, FINISH, run drops.
REQ-043 Assert abort and done in the same cycle mid-program -> IDLE next cycle, pc unchanged, no fin.
REQ-044 Assert resetn=0 asynchronously mid-ADD -> run=0 and busy=0 before the next edge; then prog_len=0 with start -> fin only.
